// File: rtl/div_32.sv
// 32-bit restoring divider, signed or unsigned, one quotient bit per clock.
// Divide-by-zero completes in a single cycle without entering the iteration loop.

module sub_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] diff,
   output logic        borrow
);
   assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

module div_32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);
   localparam int unsigned W = 32;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [W-1:0]    rem;
   logic [W-1:0]    dq;
   logic [W-1:0]    dvs;
   logic            q_neg;
   logic            r_neg;

   logic [W-1:0]    dividend_mag;
   logic [W-1:0]    divisor_mag;
   logic [W:0]      shifted;
   logic [W-1:0]    trial;
   logic            borrow;
   logic            accept;

   // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
   assign dividend_mag = (is_signed && dividend[W-1]) ? (~dividend + W'(1)) : dividend;
   assign divisor_mag  = (is_signed && divisor[W-1])  ? (~divisor + W'(1))  : divisor;

   // Shifted partial remainder can reach 33 bits when |divisor| is above 2^31.
   assign shifted = {rem, dq[W-1]};

   sub_32 u_sub (
      .a      (shifted[W-1:0]),
      .b      (dvs),
      .diff   (trial),
      .borrow (borrow)
   );

   assign accept = shifted[W] | ~borrow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         rem         <= '0;
         dq          <= '0;
         dvs         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     dq    <= dividend_mag;
                     dvs   <= divisor_mag;
                     rem   <= '0;
                     count <= '0;
                     q_neg <= is_signed & (dividend[W-1] ^ divisor[W-1]);
                     r_neg <= is_signed & dividend[W-1];
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem   <= accept ? trial : shifted[W-1:0];
               dq    <= {dq[W-2:0], accept};
               count <= count + CW'(1);
               if (count == CW'(W - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               quotient    <= q_neg ? (~dq + W'(1)) : dq;
               remainder   <= r_neg ? (~rem + W'(1)) : rem;
               div_by_zero <= 1'b0;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
